// File: rtl/mul5_sched_pkg.sv
// Shared types and constants for the round-robin 5x5 multiplier scheduler.
// The core latency is counted in edges, from the b sample to the product register.
package mul5_sched_pkg;
  localparam int OP_W     = 5;
  localparam int PROD_W   = 10;
  localparam int CORE_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    CAPT,
    RESP
  } sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr+1.
// The search wraps around, and an idle port is skipped without using up a turn.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx
);
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = ID_W'((32'(i_ptr) + 32'(off)) % 32'(N_REQ));
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul5_rr_sched.sv
// Shares one external 5x5 shift-add multiplier core among N_REQ requesters.
// Only one request is in flight at a time; results return tagged with the requester index.
module mul5_rr_sched
  import mul5_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_prod,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_s,
  output logic                    busy
);
  sched_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_idx;
  logic [N_REQ-1:0]  w_gnt;
  logic              w_accept;
  logic [OP_W-1:0]   r_mul_a, r_mul_b;
  logic              r_rsp_valid, r_busy;
  logic [ID_W-1:0]   r_rsp_id;
  logic [PROD_W-1:0] r_rsp_prod;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|req_valid) && !reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = HOLD;
      HOLD:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant is gated by reset so nothing is acknowledged in the reset cycle.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && !reset) req_ready = w_gnt;
  end

  // Operands stay in place from one accept to the next, covering the core's hold window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= ID_W'(N_REQ - 1);
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_a  <= req_a[OP_W*int'(w_idx) +: OP_W];
        r_mul_b  <= req_b[OP_W*int'(w_idx) +: OP_W];
        r_rsp_id <= w_idx;
        r_ptr    <= w_idx;
        r_busy   <= 1'b1;
      end
      if (r_state == CAPT) begin
        r_rsp_prod  <= mul_s;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == RESP && r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_busy      <= 1'b0;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_prod  = r_rsp_prod;
  assign busy      = r_busy;
endmodule

// File: tb/tb_mul5_rr_sched.sv
// Bench for mul5_rr_sched: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mul5_rr_sched;
  import mul5_sched_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_prod;
  logic [4:0]  mul_a, mul_b;
  logic [9:0]  mul_s = '0;
  logic        busy;

  mul5_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .mul_a(mul_a), .mul_b(mul_b),
    .mul_s(mul_s), .busy(busy)
  );

  always #5 clk = ~clk;

  // External core: samples b at one edge, registers a*b at the next.
  logic [4:0] core_b = '0;
  always @(posedge clk) begin
    core_b <= mul_b;
    mul_s  <= {5'b0, mul_a} * {5'b0, core_b};
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int arb(input logic [3:0] v, input int ptr);
    for (int off = 1; off <= N; off++)
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  // Transaction model: one request in flight, response CORE_LAT+1 edges after accept.
  bit m_inflight = 0;
  int m_t = 0, m_ptr = N - 1, m_mula = 0, m_mulb = 0, m_id = 0, m_prod = 0;
  bit m_rsp_valid = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_inflight <= 0; m_ptr <= N - 1; m_mula <= 0; m_mulb <= 0;
      m_id <= 0; m_prod <= 0; m_rsp_valid <= 0;
    end else if (!m_inflight) begin
      if (arb(req_valid, m_ptr) >= 0) begin
        m_inflight <= 1;
        m_t        <= 0;
        m_mula     <= int'(req_a[arb(req_valid, m_ptr)*5 +: 5]);
        m_mulb     <= int'(req_b[arb(req_valid, m_ptr)*5 +: 5]);
        m_id       <= arb(req_valid, m_ptr);
        m_ptr      <= arb(req_valid, m_ptr);
      end
    end else if (m_rsp_valid) begin
      if (rsp_ready) begin
        m_rsp_valid <= 0;
        m_inflight  <= 0;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == CORE_LAT + 1) begin
        m_rsp_valid <= 1;
        m_prod      <= m_mula * m_mulb;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      int exp_rdy;
      w = arb(req_valid, m_ptr);
      exp_rdy = (reset || m_inflight || w < 0) ? 0 : (1 << w);
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_inflight);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_prod", rsp_prod, m_prod);
      chk("mul_a", mul_a, m_mula);
      chk("mul_b", mul_b, m_mulb);
    end
  end

  // Observed handshakes for the directed checks.
  int acc_id[$], acc_cyc[$], rsp_id_q[$], rsp_prod_q[$];
  int rdy2_cnt = 0;
  always @(negedge clk) begin
    if (req_ready[2]) rdy2_cnt++;
    for (int i = 0; i < N; i++)
      if (req_ready[i] && req_valid[i]) begin
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
      end
    if (rsp_valid && rsp_ready) begin
      rsp_id_q.push_back(int'(rsp_id));
      rsp_prod_q.push_back(int'(rsp_prod));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int p, input bit v, input int a, input int b);
    req_valid[p] = v;
    req_a[p*5 +: 5] = 5'(a);
    req_b[p*5 +: 5] = 5'(b);
  endtask

  task automatic wait_ready(input int p);
    int n = 0;
    #1;
    while (!req_ready[p] && n < 20) begin step(); n++; end
    chk("wait_ready_timeout", int'(n < 20), 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    chk("wait_rsp_timeout", int'(lat < 20), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("wait_idle_timeout", int'(n < 40), 1);
  endtask

  // One request on port p with rsp_ready high; operands must hold until the response.
  task automatic do_one(input int p, input int a, input int b, input int exp_prod);
    int lat;
    int n = 0;
    set_req(p, 1, a, b);
    wait_ready(p);
    chk("grant_onehot", int'(req_ready), 1 << p);
    step();
    req_valid[p] = 1'b0;
    while (!rsp_valid && n < 20) begin
      chk("hold_mul_a", int'(mul_a), a);
      chk("hold_mul_b", int'(mul_b), b);
      step(); n++;
    end
    lat = n;
    chk("do_one_latency", lat, 3);
    chk("rsp_mul_a", int'(mul_a), a);
    chk("rsp_mul_b", int'(mul_b), b);
    chk("do_one_prod", int'(rsp_prod), exp_prod);
    chk("do_one_id", int'(rsp_id), p);
    wait_idle();
  endtask

  initial begin
    int lat;
    int n0;
    step(2);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_mul_a", int'(mul_a), 0);
    chk("reset_ready", int'(req_ready), 0);
    reset = 1'b0;
    chk_en = 1;

    // Single request on port 2, full-scale operands.
    set_req(2, 1, 31, 31);
    wait_ready(2);
    step();
    req_valid[2] = 1'b0;
    wait_rsp(lat);
    chk("t1_latency", lat, CORE_LAT + 1);
    chk("t1_rsp_id", int'(rsp_id), 2);
    chk("t1_rsp_prod", int'(rsp_prod), 961);
    wait_idle();
    chk("t1_ready_cycles", rdy2_cnt, 1);

    // All ports valid after reset: strict rotation, 5-cycle issue period.
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 3);
    step();
    reset = 1'b0;
    acc_id.delete(); acc_cyc.delete(); rsp_id_q.delete(); rsp_prod_q.delete();
    step(22);
    req_valid = '0;
    wait_idle();
    chk("t2_nacc", int'(acc_id.size() >= 5), 1);
    chk("t2_nrsp", int'(rsp_prod_q.size() >= 4), 1);
    if (acc_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t2_order", acc_id[i], i % N);
      for (int i = 0; i < 4; i++) chk("t2_period", acc_cyc[i+1] - acc_cyc[i], 5);
    end
    if (rsp_prod_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_prod", rsp_prod_q[i], 3 * (i + 1));

    // Consumer stall: response held, nothing granted until the handshake.
    rsp_ready = 1'b0;
    set_req(1, 1, 7, 5);
    wait_ready(1);
    step();
    req_valid[1] = 1'b0;
    set_req(3, 1, 2, 2);
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      chk("t3_prod", int'(rsp_prod), 35);
      chk("t3_id", int'(rsp_id), 1);
      chk("t3_ready", int'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_ready_pre_hs", int'(req_ready), 0);
    step();
    chk("t3_ready_port3", int'(req_ready), 4'b1000);
    step();
    req_valid[3] = 1'b0;
    wait_rsp(lat);
    chk("t3_p3_prod", int'(rsp_prod), 4);
    wait_idle();

    // Zero operands.
    do_one(0, 0, 17, 0);
    do_one(1, 19, 0, 0);

    // Reset while in HOLD: request dropped, port 0 wins first afterwards.
    n0 = rsp_id_q.size();
    set_req(2, 1, 3, 4);
    wait_ready(2);
    step();
    req_valid[2] = 1'b0;
    set_req(0, 1, 5, 6);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_rsp_valid", int'(rsp_valid), 0);
    chk("t5_mul_a", int'(mul_a), 0);
    chk("t5_mul_b", int'(mul_b), 0);
    chk("t5_ready", int'(req_ready), 4'b0001);
    step();
    req_valid[0] = 1'b0;
    wait_rsp(lat);
    wait_idle();
    chk("t5_nrsp", rsp_id_q.size() - n0, 1);
    if (rsp_id_q.size() == n0 + 1) begin
      chk("t5_rsp_id", rsp_id_q[n0], 0);
      chk("t5_rsp_prod", rsp_prod_q[n0], 30);
    end

    // Pointer wrap: from ptr=3 only port 0 valid, then ptr=0 favours port 1.
    do_one(3, 2, 3, 6);
    do_one(0, 9, 9, 81);
    set_req(0, 1, 1, 1);
    set_req(1, 1, 2, 2);
    #1;
    chk("t6_ptr0_pick", int'(req_ready), 4'b0010);
    step();
    req_valid = '0;
    wait_rsp(lat);
    chk("t6_prod", int'(rsp_prod), 4);
    wait_idle();

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mul5_rr_sched.md
# mul5_rr_sched

Round-robin scheduler that shares one 5×5 unsigned shift-add multiplier core among `N_REQ` requesters. It sits between the requesters and the multiplier core. The block accepts one request at a time through a per-port valid/ready handshake. It drives the operands into the core, honouring the core's operand-hold contract, captures the 10-bit product, and returns it on a single response channel tagged with the requester index.

## Interface
- `N_REQ`, 4: number of requesters. Legal values are 2..8.
- `ID_W`, 2: width of `rsp_id`. Must equal ceil(log2(`N_REQ`)).
- `clk` in 1: clock. All logic is rising-edge.
- `reset` in 1: reset, synchronous, active-high. The clock is `clk`.
- `req_valid` in `N_REQ`: per-port request valid. It must not depend combinationally on `req_ready`.
- `req_ready` out `N_REQ`: per-port grant. One-hot or zero.
- `req_a` in 5·`N_REQ`: multiplicand. Port i uses bits [5i+4:5i].
- `req_b` in 5·`N_REQ`: multiplier. Port i uses bits [5i+4:5i].
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: the consumer accepts the product.
- `rsp_id` out `ID_W`: index of the requester that issued the product.
- `rsp_prod` out 10: unsigned product, equal to a·b.
- `mul_a` out 5: core operand a. Registered.
- `mul_b` out 5: core operand b. Registered.
- `mul_s` in 10: core product. The core registers `mul_b` at edge k and registers `mul_s` at edge k+1. `mul_a` must be stable from edge k-1 through edge k+1.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, ISSUE, HOLD, CAPT and RESP.
- **IDLE**
  - Arbitrate among asserted `req_valid`. Priority starts at port (`ptr`+1) mod `N_REQ` and wraps.
  - Assert `req_ready` combinationally for the winner only.
  - On the handshake edge, latch the winner's a and b into `mul_a`/`mul_b`, latch its index into `rsp_id`, set `ptr` to the winner, and go to ISSUE.
- **ISSUE**: the core samples `mul_b` at the end of this cycle. Go to HOLD.
- **HOLD**: the core registers its product at the end of this cycle. Go to CAPT.
- **CAPT**: `mul_s` is valid. Latch it into `rsp_prod`, set `rsp_valid`, and go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_id` and `rsp_prod` stable until `rsp_valid`&`rsp_ready`.
  - On that edge, clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in every state except IDLE. Only one request is ever in flight.
- `mul_a`/`mul_b` stay constant from the accept edge until the next accept edge.
- Arithmetic is unsigned. The product range is 0..961, so no overflow occurs in 10 bits.
- Requesters that lose arbitration keep `req_valid` and are not acknowledged.
- A port with `req_valid`=0 is skipped without consuming a turn.
- `ptr` wraps from `N_REQ`-1 to 0.
- Reset values:
  - state = IDLE
  - `ptr` = `N_REQ`-1, so port 0 has first priority
  - `mul_a` = `mul_b` = 0
  - `rsp_valid` = 0, `rsp_prod` = 0, `rsp_id` = 0
  - `busy` = 0
  - `req_ready` = 0 during the reset cycle
- Reset mid-operation: the in-flight request is discarded with no response. The next accept follows normal reset priority.

## Timing
- Accept at edge E0 → `rsp_valid` high in the cycle after E3. The accept-to-response latency is 3 cycles.
- The earliest response handshake is E4. The state is IDLE after E4, and the next accept can occur at E5. Minimum issue period is 5 cycles.
- `req_ready` depends combinationally on `req_valid` and state. All other outputs are registered.
- Holding `rsp_ready` low stalls indefinitely in RESP. No new request is granted while stalled.

## Structure
- Package `mul5_sched_pkg` contains:
  - `OP_W`=5 and `PROD_W`=10
  - the state enum `sched_state_t` (IDLE, ISSUE, HOLD, CAPT, RESP)
  - `CORE_LAT`=2, the number of edges from b sample to product
- Sub-module `rr_pick` is purely combinational:
  - inputs: `N_REQ`-bit request vector and `ptr`
  - outputs: one-hot grant and the encoded index
- The multiplier core is external. This block only drives and samples it.

## Test plan
- Reset, then port 2 requests a=31, b=31 with `rsp_ready`=1 → `req_ready`[2] is asserted for exactly 1 cycle; `rsp_id`=2 and `rsp_prod`=961, with `rsp_valid` high 3 cycles after accept.
- All 4 ports are valid continuously after reset, with port i carrying a=i+1, b=3 → grants arrive in order 0,1,2,3,0, each 5 cycles apart; products are 3, 6, 9, 12.
- Port 1 requests a=7, b=5 and `rsp_ready` is held low for 10 cycles → `rsp_prod`=35 and `rsp_id`=1 stay stable, `req_ready` stays 0, and port 3, waiting meanwhile, is granted only after the handshake.
- Request a=0, b=17 (b=10001) and request a=19, b=0 → both produce product 0. `mul_a`/`mul_b` hold their operands through CAPT.
- Reset asserted in HOLD → the next cycle shows IDLE with `rsp_valid`=0, `busy`=0 and `mul_a`=`mul_b`=0, no response is emitted, and the pending port 0 request is granted first.
- `ptr`=3 and only port 0 is valid → port 0 is granted (wrap-around), then `ptr`=0.
